flip_arb_ctrl: RTL and testbench

- Clocked controller that shares one half-swap (flip) datapath between two dual-rail producers, A and B.
- Samples each producer's dual-rail word and detects completion. Arbitrates round-robin, optionally swaps the word's upper and lower halves per requester, and presents the result on a dual-rail output.
- Runs a four-phase return-to-zero handshake on both sides.
- Sits between the clocked sequencing logic and the dual-rail function blocks.

---
 rtl/flip_arb_ctrl.sv | 145 ++++++++++++++
 tb/tb_flip_arb_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flip_arb_ctrl.sv
// rtl/flip_arb_ctrl.sv - round-robin shared half-swap controller for two dual-rail producers
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_a      producer A dual-rail word (per bit: 01=false, 10=true, 00=null, 11=illegal)
//   flip_a    swap halves of A's word when A is granted
//   ack_a     four-phase acknowledge to A
//   in_b      producer B dual-rail word
//   flip_b    swap halves of B's word when B is granted
//   ack_b     four-phase acknowledge to B
//   out       registered dual-rail result
//   out_ack   consumer acknowledge
//   grant     owner of the current transfer (0=A, 1=B)
//   err       sticky illegal-code flag
//   xfer_cnt  completed transfers, wraps modulo 2^CNT_W
module flip_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    localparam int RAIL_NUM = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]     in_a,
    input  logic                               flip_a,
    output logic                               ack_a,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]     in_b,
    input  logic                               flip_b,
    output logic                               ack_b,
    output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
    input  logic                               out_ack,
    output logic                               grant,
    output logic                               err,
    output logic [CNT_W-1:0]                   xfer_cnt
);

    if ((WIDTH % 2) != 0) begin : g_width_check
        $error("flip_arb_ctrl: WIDTH must be even");
    end

    localparam int H = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef logic [WIDTH-1:0][RAIL_NUM-1:0] word_t;
    typedef enum logic [1:0] {IDLE, DATA, RTZ} state_t;

    state_t state;
    logic   last_grant;

    logic  cmp_a, cmp_b;
    logic  ill_a, ill_b;
    logic  null_a, null_b;
    logic  sel_b;
    logic  win;
    word_t word_sel;
    logic  flip_sel;
    word_t word_next;

    // Completion requires every bit to carry exactly one rail, so a
    // complete word is by construction free of illegal 11 codes.
    always_comb begin
        cmp_a = 1'b1;
        cmp_b = 1'b1;
        ill_a = 1'b0;
        ill_b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cmp_a = cmp_a & ((in_a[i] == 2'b01) || (in_a[i] == 2'b10));
            cmp_b = cmp_b & ((in_b[i] == 2'b01) || (in_b[i] == 2'b10));
            ill_a = ill_a | (in_a[i] == 2'b11);
            ill_b = ill_b | (in_b[i] == 2'b11);
        end
        null_a = (in_a == '0);
        null_b = (in_b == '0);
    end

    // B wins only if it is ready and A is not, or both are ready and A
    // had the previous transfer.
    always_comb begin
        sel_b    = cmp_b && (!cmp_a || (last_grant == 1'b0));
        win      = cmp_a || cmp_b;
        word_sel = sel_b ? in_b : in_a;
        flip_sel = sel_b ? flip_b : flip_a;
        word_next = word_sel;
        if (flip_sel) begin
            word_next[WIDTH-1:H] = word_sel[H-1:0];
            word_next[H-1:0]     = word_sel[WIDTH-1:H];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            out        <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            err        <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            if (ill_a || ill_b) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    out   <= '0;
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (win) begin
                        out   <= word_next;
                        grant <= sel_b;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (out_ack) begin
                        out <= '0;
                        if (grant) begin
                            ack_b <= 1'b1;
                        end else begin
                            ack_a <= 1'b1;
                        end
                        state <= RTZ;
                    end
                end
                RTZ: begin
                    if (!out_ack && (grant ? null_b : null_a)) begin
                        ack_a      <= 1'b0;
                        ack_b      <= 1'b0;
                        last_grant <= grant;
                        xfer_cnt   <= xfer_cnt + CNT_ONE;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= '0;
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flip_arb_ctrl.sv
// tb/tb_flip_arb_ctrl.sv - directed self-checking bench for flip_arb_ctrl
module tb_flip_arb_ctrl;

    typedef logic [3:0][1:0] word_t;

    logic       clk;
    logic       rst_n;
    word_t      in_a;
    logic       flip_a;
    logic       ack_a;
    word_t      in_b;
    logic       flip_b;
    logic       ack_b;
    word_t      out;
    logic       out_ack;
    logic       grant;
    logic       err;
    logic [1:0] xfer_cnt;

    int tests;
    int fails;

    flip_arb_ctrl #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_a(in_a), .flip_a(flip_a), .ack_a(ack_a),
        .in_b(in_b), .flip_b(flip_b), .ack_b(ack_b),
        .out(out), .out_ack(out_ack), .grant(grant),
        .err(err), .xfer_cnt(xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t enc(input logic [3:0] v);
        word_t w;
        for (int i = 0; i < 4; i++) begin
            w[i] = v[i] ? 2'b10 : 2'b01;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_a = '0; in_b = '0; flip_a = 1'b0; flip_b = 1'b0; out_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_a = '0; in_b = '0; flip_a = 1'b0; flip_b = 1'b0; out_ack = 1'b0;
        #3;
        tests++;
        if ({out, ack_a, ack_b, err, xfer_cnt, grant} !== 14'b0) begin
            fails++;
            $display("FAIL reset_state: got out=%h ack_a=%b ack_b=%b err=%b cnt=%0d grant=%b want all zero",
                     out, ack_a, ack_b, err, xfer_cnt, grant);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        in_a = enc(4'b0011); flip_a = 1'b0;
        tick();
        tests++;
        if (out !== enc(4'b0011) || grant !== 1'b0 || ack_a !== 1'b0) begin
            fails++;
            $display("FAIL basic_data: got out=%h grant=%b ack_a=%b want out=%h grant=0 ack_a=0",
                     out, grant, ack_a, enc(4'b0011));
        end
        out_ack = 1'b1;
        tick();
        tests++;
        if (ack_a !== 1'b1 || out !== 8'h00) begin
            fails++;
            $display("FAIL basic_ack_rise: got ack_a=%b out=%h want ack_a=1 out=00", ack_a, out);
        end
        in_a = '0;
        tick();
        tests++;
        if (ack_a !== 1'b1 || xfer_cnt !== 2'd0) begin
            fails++;
            $display("FAIL basic_wait_out_ack: got ack_a=%b cnt=%0d want ack_a=1 cnt=0", ack_a, xfer_cnt);
        end
        out_ack = 1'b0;
        tick();
        tests++;
        if (ack_a !== 1'b0 || xfer_cnt !== 2'd1) begin
            fails++;
            $display("FAIL basic_rtz: got ack_a=%b cnt=%0d want ack_a=0 cnt=1", ack_a, xfer_cnt);
        end
    endtask

    task automatic test_flip();
        in_a = enc(4'b0011); flip_a = 1'b1;
        tick();
        tests++;
        if (out !== enc(4'b1100) || grant !== 1'b0) begin
            fails++;
            $display("FAIL flip_a: got out=%h grant=%b want out=%h grant=0", out, grant, enc(4'b1100));
        end
        out_ack = 1'b1;
        tick();
        in_a = '0; out_ack = 1'b0; flip_a = 1'b0;
        tick();
        in_b = enc(4'b1000); flip_b = 1'b1;
        tick();
        tests++;
        if (out !== enc(4'b0010) || grant !== 1'b1) begin
            fails++;
            $display("FAIL flip_b: got out=%h grant=%b want out=%h grant=1", out, grant, enc(4'b0010));
        end
        out_ack = 1'b1;
        tick();
        tests++;
        if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
            fails++;
            $display("FAIL flip_b_ack: got ack_a=%b ack_b=%b want ack_a=0 ack_b=1", ack_a, ack_b);
        end
        in_b = '0; out_ack = 1'b0; flip_b = 1'b0;
        tick();
        tests++;
        if (ack_b !== 1'b0 || xfer_cnt !== 2'd3) begin
            fails++;
            $display("FAIL flip_b_rtz: got ack_b=%b cnt=%0d want ack_b=0 cnt=3", ack_b, xfer_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic exp_g [3] = '{1'b0, 1'b1, 1'b0};
        apply_reset();
        in_a = enc(4'b0101);
        in_b = enc(4'b1010);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (grant !== exp_g[k] || out !== (exp_g[k] ? enc(4'b1010) : enc(4'b0101))) begin
                fails++;
                $display("FAIL rr_grant_%0d: got grant=%b out=%h want grant=%b", k, grant, out, exp_g[k]);
            end
            out_ack = 1'b1;
            tick();
            tests++;
            if ((exp_g[k] ? {ack_b, ack_a} : {ack_a, ack_b}) !== 2'b10) begin
                fails++;
                $display("FAIL rr_ack_%0d: got ack_a=%b ack_b=%b want only side %b acked", k, ack_a, ack_b, exp_g[k]);
            end
            if (exp_g[k]) in_b = '0; else in_a = '0;
            out_ack = 1'b0;
            tick();
            in_a = enc(4'b0101);
            in_b = enc(4'b1010);
        end
        in_a = '0;
        in_b = '0;
        tick();
    endtask

    task automatic test_illegal();
        in_b = {2'b01, 2'b11, 2'b01, 2'b01};
        tick();
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_err_set: got err=%b want 1", err);
        end
        tick();
        tick();
        tests++;
        if (out !== 8'h00 || ack_b !== 1'b0) begin
            fails++;
            $display("FAIL illegal_not_granted: got out=%h ack_b=%b want out=00 ack_b=0", out, ack_b);
        end
        in_a = enc(4'b1001);
        tick();
        tests++;
        if (out !== enc(4'b1001) || grant !== 1'b0) begin
            fails++;
            $display("FAIL illegal_a_runs: got out=%h grant=%b want out=%h grant=0", out, grant, enc(4'b1001));
        end
        out_ack = 1'b1;
        tick();
        in_a = '0; out_ack = 1'b0;
        tick();
        tests++;
        if (err !== 1'b1 || ack_b !== 1'b0 || ack_a !== 1'b0) begin
            fails++;
            $display("FAIL illegal_sticky: got err=%b ack_a=%b ack_b=%b want err=1 acks 0", err, ack_a, ack_b);
        end
        in_b = '0;
    endtask

    task automatic test_async_reset();
        in_a = enc(4'b0101); flip_a = 1'b0;
        tick();
        tests++;
        if (out !== enc(4'b0101)) begin
            fails++;
            $display("FAIL areset_pre: got out=%h want %h", out, enc(4'b0101));
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out !== 8'h00 || ack_a !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: got out=%h ack_a=%b want out=00 ack_a=0", out, ack_a);
        end
        in_a = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (xfer_cnt !== 2'd0 || err !== 1'b0 || out !== 8'h00) begin
            fails++;
            $display("FAIL areset_after: got cnt=%0d err=%b out=%h want 0 0 00", xfer_cnt, err, out);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0] vals [5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
        logic       flips [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exps [5]   = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1111};
        logic [1:0] cnts [5]   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            in_a = enc(vals[k]); flip_a = flips[k];
            for (int d = 0; d < 3; d++) begin
                tick();
                if (d == 1) in_a = enc(~vals[k]);
                tests++;
                if (out !== enc(exps[k])) begin
                    fails++;
                    $display("FAIL wrap_data_%0d_%0d: got out=%h want %h", k, d, out, enc(exps[k]));
                end
            end
            out_ack = 1'b1;
            tick();
            in_a = '0; out_ack = 1'b0;
            tick();
            tests++;
            if (xfer_cnt !== cnts[k]) begin
                fails++;
                $display("FAIL wrap_cnt_%0d: got cnt=%0d want %0d", k, xfer_cnt, cnts[k]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_flip();
        test_round_robin();
        test_illegal();
        test_async_reset();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
